carry_select_adder: RTL and testbench
=====================================

// Module: carry_select_adder
// PURPOSE
//   WIDTH-bit carry-select adder: sum/cout = a + b + cin.
//   Low block ripples directly from cin. Each upper block precomputes
//   results for carry-in 0 and 1, and the real block carry selects between them.
//   Used as a fast datapath adder. Optional output register for pipelined use.
// PARAMETERS
//   WIDTH    4  operand/sum width in bits; must be a multiple of BLOCK, >= BLOCK
//   BLOCK    2  bits per carry-select block
//   REG_OUT  0  0 = combinational outputs; 1 = outputs registered on clk
// PORTS
//   clk    in   1      clock; only used when REG_OUT=1
//   rst_n  in   1      asynchronous active-low reset; only used when REG_OUT=1
//   a      in   WIDTH  operand A, unsigned
//   b      in   WIDTH  operand B, unsigned
//   cin    in   1      carry in
//   sum    out  WIDTH  (a+b+cin) mod 2^WIDTH
//   cout   out  1      bit WIDTH of a+b+cin
// BEHAVIOUR
//   - Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//   - Arithmetic: {cout,sum} = a + b + cin. All operands unsigned.
//     Exact for every input combination; there is no saturation.
//   - Block 0 (bits BLOCK-1:0): ripple add with carry-in = cin.
//   - Block k>0:
//     - Two ripple adders compute {c0,s0} = a_k + b_k + 0 and {c1,s1} = a_k + b_k + 1.
//     - A mux takes the previous block's carry c_prev and selects s1/c1 when c_prev=1,
//       otherwise s0/c0.
//     - cout is the selected carry of the top block.
//   - REG_OUT=0:
//     - Purely combinational; zero latency; outputs settle within the same delta.
//     - clk and rst_n are ignored; no storage is inferred.
//   - REG_OUT=1:
//     - {cout,sum} are registered on the rising edge of clk; latency 1 cycle.
//     - rst_n low clears sum=0 and cout=0 immediately, independent of clk.
//     - Release of reset takes effect at the next rising edge.
//     - Reset asserted mid-stream discards the in-flight result.
//   - X/Z on any input may propagate; no input masking is required.
//   - Full-carry boundary: all-ones + all-ones + 1 gives sum = all-ones, cout = 1.
//   - Wrap-around: all-ones + 0 + 1 gives sum = 0, cout = 1.
// STRUCTURE
//   - Sub-module rca_block (BLOCK-bit ripple-carry adder: a, b, cin -> s, co), built from
//     full-adder equations.
//   - Instantiate one rca_block for block 0 and two per upper block.
//   - Selection muxes and block-carry chain live in a generate loop in the top module.
//   - No shared package needed; the WIDTH%BLOCK==0 check is an elaboration-time assertion.
// TESTING  (WIDTH=4, BLOCK=2, REG_OUT=0, check after 10 ns settle)
//   a=0000 b=0000 cin=0 -> sum=0000 cout=0; a=0101 b=0011 cin=0 -> sum=1000 cout=0
//   a=0101 b=0011 cin=1 -> sum=1001 cout=0; a=1010 b=0101 cin=0 -> sum=1111 cout=0
//   a=1111 b=0001 cin=0 -> 0000/1; a=1111 b=0001 cin=1 -> 0001/1; a=1010 b=0101 cin=1 -> 0000/1
//   a=1101 b=0110 cin=1 -> sum=0100 cout=1; a=1111 b=1111 cin=1 -> sum=1111 cout=1
//   Exhaustive: all 512 combinations of a, b, cin -> {cout,sum} == a+b+cin
//   REG_OUT=1:
//     - Result appears one clk edge after the inputs are applied.
//     - Drive rst_n=0 between clock edges -> sum/cout go to 0 immediately.

Source files
------------

// File: rtl/carry_select_adder_pkg.sv
// Shared helpers for the carry-select adder: the full-adder equation used by every
// ripple block, and the default geometry.
package carry_select_adder_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_BLOCK = 2;

    // Returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/carry_select_adder_rca_block.sv
// BLOCK-bit ripple-carry adder built from full-adder equations; one of these
// forms each half of a carry-select stage.
module rca_block
    import carry_select_adder_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             co
);

    always_comb begin : p_ripple
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < BLOCK; i++) begin
            {c, s[i]} = full_add(a[i], b[i], c);
        end
        co = c;
    end

endmodule

// File: rtl/carry_select_adder.sv
// WIDTH-bit carry-select adder: block 0 ripples from cin, each upper block picks
// between precomputed carry-in-0 / carry-in-1 results. Optional output register.
module carry_select_adder
    import carry_select_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BLOCK   = DEF_BLOCK,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_geometry
        $error("carry_select_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH:0]   res_d;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        logic c_in;
        logic c_out;

        if (k == 0) begin : g_first
            assign c_in = cin;
            rca_block #(.BLOCK(BLOCK)) u_rca (
                .a   (a[BLOCK-1:0]),
                .b   (b[BLOCK-1:0]),
                .cin (c_in),
                .s   (sum_c[BLOCK-1:0]),
                .co  (c_out)
            );
        end else begin : g_sel
            logic [BLOCK-1:0] s0, s1;
            logic             c0, c1;

            assign c_in = g_blk[k-1].c_out;

            rca_block #(.BLOCK(BLOCK)) u_rca0 (
                .a   (a[k*BLOCK +: BLOCK]),
                .b   (b[k*BLOCK +: BLOCK]),
                .cin (1'b0),
                .s   (s0),
                .co  (c0)
            );
            rca_block #(.BLOCK(BLOCK)) u_rca1 (
                .a   (a[k*BLOCK +: BLOCK]),
                .b   (b[k*BLOCK +: BLOCK]),
                .cin (1'b1),
                .s   (s1),
                .co  (c1)
            );

            // Ternary select lets an X carry merge both candidates rather than hide one.
            assign sum_c[k*BLOCK +: BLOCK] = c_in ? s1 : s0;
            assign c_out                   = c_in ? c1 : c0;
        end
    end

    assign res_d = {g_blk[NBLK-1].c_out, sum_c};

    if (REG_OUT) begin : g_reg
        logic [WIDTH:0] res_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q <= '0;
            end else begin
                res_q <= res_d;
            end
        end

        assign {cout, sum} = res_q;
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign {cout, sum}    = res_d;
    end

endmodule

// File: tb/tb_carry_select_adder.sv
// Directed and exhaustive checks of the carry-select adder in both combinational
// and registered builds, using an expected-result queue.
module tb_carry_select_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] sum_c, sum_r;
    logic       cout_c, cout_r;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [4:0] sb_q[$];

    carry_select_adder #(.WIDTH(4), .BLOCK(2), .REG_OUT(1'b0)) dut_c (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum_c),
        .cout (cout_c)
    );

    carry_select_adder #(.WIDTH(4), .BLOCK(2), .REG_OUT(1'b1)) dut_r (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum_r),
        .cout (cout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag, input logic [4:0] obs);
        logic [4:0] exp;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed %b expected <scoreboard empty>", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            cmp(tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        a   = av;
        b   = bv;
        cin = cv;
    endtask

    // Hand-worked vectors: {a, b, cin, expected {cout,sum}}.
    typedef struct {
        logic [3:0] av;
        logic [3:0] bv;
        logic       cv;
        logic [4:0] exp;
    } vec_t;

    vec_t dir_vec[9] = '{
        '{4'b0000, 4'b0000, 1'b0, 5'b0_0000},
        '{4'b0101, 4'b0011, 1'b0, 5'b0_1000},
        '{4'b0101, 4'b0011, 1'b1, 5'b0_1001},
        '{4'b1010, 4'b0101, 1'b0, 5'b0_1111},
        '{4'b1111, 4'b0001, 1'b0, 5'b1_0000},
        '{4'b1111, 4'b0001, 1'b1, 5'b1_0001},
        '{4'b1010, 4'b0101, 1'b1, 5'b1_0000},
        '{4'b1101, 4'b0110, 1'b1, 5'b1_0100},
        '{4'b1111, 4'b1111, 1'b1, 5'b1_1111}
    };

    initial begin
        logic [4:0] model;
        logic [3:0] ra, rb;
        logic       rc;

        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0);
        #3;
        cmp("reg_reset_state", {cout_r, sum_r}, 5'b0_0000);

        // Combinational build: directed table, 10 ns settle.
        foreach (dir_vec[i]) begin
            drive(dir_vec[i].av, dir_vec[i].bv, dir_vec[i].cv);
            sb_q.push_back(dir_vec[i].exp);
            #10;
            pop_cmp($sformatf("comb_dir%0d", i), {cout_c, sum_c});
        end

        // Wrap-around: all-ones + 0 + 1.
        drive(4'b1111, 4'b0000, 1'b1);
        sb_q.push_back(5'b1_0000);
        #10;
        pop_cmp("comb_wrap", {cout_c, sum_c});

        // Exhaustive sweep against the bench's own arithmetic.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    drive(4'(ai), 4'(bi), 1'(ci));
                    model = 5'(ai + bi + ci);
                    sb_q.push_back(model);
                    #2;
                    pop_cmp($sformatf("comb_exh_%0d_%0d_%0d", ai, bi, ci), {cout_c, sum_c});
                end
            end
        end

        // Registered build: result must not appear before the edge, then appear after it.
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1101, 4'b0110, 1'b1);
        #1;
        cmp("reg_no_early_update", {cout_r, sum_r}, 5'b0_0000);
        sb_q.push_back(5'b1_0100);
        @(posedge clk);
        #1;
        pop_cmp("reg_latency1", {cout_r, sum_r});

        // Back-to-back stream of random operands.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            drive(ra, rb, rc);
            sb_q.push_back(5'({1'b0, ra} + {1'b0, rb} + {4'b0, rc}));
            @(posedge clk);
            #1;
            pop_cmp($sformatf("reg_stream%0d", i), {cout_r, sum_r});
        end

        @(negedge clk);
        drive(4'b1111, 4'b1111, 1'b1);
        sb_q.push_back(5'b1_1111);
        @(posedge clk);
        #1;
        pop_cmp("reg_full_carry", {cout_r, sum_r});

        // Mid-cycle reset clears immediately and drops the pending operands.
        @(negedge clk);
        drive(4'b0101, 4'b0011, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("reg_async_clear", {cout_r, sum_r}, 5'b0_0000);
        @(posedge clk);
        #1;
        cmp("reg_hold_in_reset", {cout_r, sum_r}, 5'b0_0000);
        cmp("comb_ignores_reset", {cout_c, sum_c}, 5'b0_1000);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cmp("reg_release_waits_edge", {cout_r, sum_r}, 5'b0_0000);
        sb_q.push_back(5'b0_1000);
        @(posedge clk);
        #1;
        pop_cmp("reg_after_release", {cout_r, sum_r});

        n_cmp++;
        assert (sb_q.size() == 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
